// File: rtl/uart_src_pkg.sv
// Shared types and helpers for the UART test-pattern source.
// State encoding, ROM formula and default parameter values.
package uart_src_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_HOLD,
    S_DRAIN,
    S_GAP
  } state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_GAP_CYC = 16;

  function automatic logic [31:0] rom_word(input int unsigned i);
    return (i + 32'd1) * 32'h11;
  endfunction

endpackage

// File: rtl/uart_src_rom.sv
// Fixed pattern ROM for the UART test-pattern source.
// Combinational read; word i = (i+1)*8'h11 truncated to DATA_W.
module uart_src_rom
  import uart_src_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] rom_t [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom_t[g] = DATA_W'(rom_word(g));
  end

  assign data = rom_t[idx];

endmodule

// File: rtl/uart_pattern_source.sv
// Handshaked ROM pattern source feeding the UART transmitter.
// Optional pass checksum word: define UART_SRC_CHECKSUM_EN.
module uart_pattern_source
  import uart_src_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_loop,
  input  logic [ADDR_W:0]   len,
  input  logic              tx_busy,
  output logic              wr_Sig,
  output logic [DATA_W-1:0] test_Data,
  output logic              active,
  output logic              done
);

  localparam int CNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [ADDR_W:0] N_MAX = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                act_q, act_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rom_data;
  logic [DATA_W-1:0]   word;
  logic [ADDR_W:0]     n_eff;
  logic                last_idx;
  logic                word_end;
  logic                pass_end;
`ifdef UART_SRC_CHECKSUM_EN
  logic                ck_q, ck_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  uart_src_rom #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rom (
    .idx (idx_q),
    .data(rom_data)
  );

  assign n_eff = (len == '0 || len > N_MAX) ? N_MAX : len;
  assign last_idx = ({1'b0, idx_q} == n_q - 1'b1);

`ifdef UART_SRC_CHECKSUM_EN
  assign word = ck_q ? csum_q : rom_data;
`else
  assign word = rom_data;
`endif

  assign wr_Sig    = (state_q == S_SEND);
  assign test_Data = wr_Sig ? word : data_q;
  assign active    = act_q;
  assign done      = done_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    done_d   = 1'b0;
    data_d   = test_Data;
    word_end = 1'b0;
    pass_end = 1'b0;
`ifdef UART_SRC_CHECKSUM_EN
    ck_d     = ck_q;
    csum_d   = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !tx_busy) begin
          n_d     = n_eff;
          idx_d   = '0;
          act_d   = 1'b1;
          state_d = S_SEND;
`ifdef UART_SRC_CHECKSUM_EN
          ck_d    = 1'b0;
          csum_d  = '0;
`endif
        end
      end
      S_SEND: begin
        state_d = S_HOLD;
`ifdef UART_SRC_CHECKSUM_EN
        if (!ck_q) csum_d = csum_q ^ rom_data;
`endif
      end
      // Busy is not yet visible here; the transmitter lags one cycle.
      S_HOLD: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!tx_busy) begin
          cnt_d = '0;
          if (GAP_CYC == 0) word_end = 1'b1;
          else state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) word_end = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (word_end) begin
      cnt_d = '0;
      if (!last_idx) begin
        idx_d   = idx_q + 1'b1;
        state_d = S_SEND;
      end else begin
`ifdef UART_SRC_CHECKSUM_EN
        if (!ck_q) begin
          ck_d    = 1'b1;
          state_d = S_SEND;
        end else begin
          pass_end = 1'b1;
        end
`else
        pass_end = 1'b1;
`endif
      end
    end

    if (pass_end) begin
      done_d = 1'b1;
`ifdef UART_SRC_CHECKSUM_EN
      ck_d   = 1'b0;
      csum_d = '0;
`endif
      if (mode_loop) begin
        idx_d   = '0;
        state_d = S_SEND;
      end else begin
        act_d   = 1'b0;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
`ifdef UART_SRC_CHECKSUM_EN
      ck_q    <= 1'b0;
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      done_q  <= done_d;
      data_q  <= data_d;
`ifdef UART_SRC_CHECKSUM_EN
      ck_q    <= ck_d;
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_pattern_source.sv
// Directed bench for uart_pattern_source (DEPTH=8, GAP_CYC=4).
// Transmitter model stays busy 10 cycles after each strobe.
module tb_uart_pattern_source;

`ifdef UART_SRC_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       mode_loop = 1'b0;
  logic [3:0] len = 4'd0;
  logic       tx_busy;
  logic       wr_Sig;
  logic [7:0] test_Data;
  logic       active;
  logic       done;

  logic       hold_busy = 1'b0;
  int         bcnt = 0;

  int         errors = 0;
  int         checks = 0;

  int         cyc = 0;
  logic [7:0] got[$];
  int         strobe_cyc[$];
  int         done_cyc[$];
  logic       done_act[$];

  uart_pattern_source #(
    .DATA_W (8),
    .DEPTH  (8),
    .GAP_CYC(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode_loop(mode_loop),
    .len      (len),
    .tx_busy  (tx_busy),
    .wr_Sig   (wr_Sig),
    .test_Data(test_Data),
    .active   (active),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) bcnt <= 0;
    else if (wr_Sig) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) || hold_busy;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_Sig) begin
      got.push_back(test_Data);
      strobe_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_act.push_back(active);
    end
  end

  typedef struct {
    logic [3:0] len;
    int         exp_n;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_word(int n, int i);
    logic [7:0] x;
    x = 8'h00;
    if (i < n) return 8'((i + 1) * 17);
    for (int k = 0; k < n; k++) x = x ^ 8'((k + 1) * 17);
    return x;
  endfunction

  task automatic clear_log();
    got.delete();
    strobe_cyc.delete();
    done_cyc.delete();
    done_act.delete();
  endtask

  task automatic wait_idle(string nm);
    int k;
    k = 0;
    while (active && k < 2000) begin
      tick();
      k++;
    end
    chk({nm, "_timeout"}, 32'(active), 32'd0);
    tick();
  endtask

  task automatic wait_strobes(string nm, int n);
    int k;
    k = 0;
    while (got.size() < n && k < 2000) begin
      tick();
      k++;
    end
    chk({nm, "_timeout"}, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic run_pass(logic [3:0] l, logic lp);
    len = l;
    mode_loop = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int w;
    vecs[0] = '{4'd3,  3};
    vecs[1] = '{4'd0,  8};
    vecs[2] = '{4'd8,  8};
    vecs[3] = '{4'd9,  8};
    vecs[4] = '{4'd1,  1};
    vecs[5] = '{4'd15, 8};

    repeat (3) tick();
    chk("rst_wr", 32'(wr_Sig), 32'd0);
    chk("rst_data", 32'(test_Data), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();

    // start accepted at the next edge, strobe visible the cycle after
    clear_log();
    len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_wr", 32'(wr_Sig), 32'd1);
    chk("lat_data", 32'(test_Data), 32'h11);
    chk("lat_active", 32'(active), 32'd1);
    wait_idle("lat");

    for (int v = 0; v < 6; v++) begin
      clear_log();
      run_pass(vecs[v].len, 1'b0);
      wait_idle($sformatf("v%0d", v));
      w = vecs[v].exp_n + CK;
      chk($sformatf("v%0d_count", v), 32'(got.size()), 32'(w));
      for (int i = 0; i < w && i < got.size(); i++)
        chk($sformatf("v%0d_w%0d", v, i), 32'(got[i]),
            32'(exp_word(vecs[v].exp_n, i)));
      chk($sformatf("v%0d_dones", v), 32'(done_cyc.size()), 32'd1);
      if (done_act.size() > 0)
        chk($sformatf("v%0d_act_at_done", v), 32'(done_act[0]), 32'd0);
      if (v == 0 && strobe_cyc.size() >= 2 && done_cyc.size() >= 1) begin
        chk("spacing", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd16);
        chk("done_lat", 32'(done_cyc[0] - strobe_cyc[strobe_cyc.size()-1]),
            32'd16);
      end
    end

    // loop mode, mode_loop dropped during the second pass
    clear_log();
    w = 2 + CK;
    run_pass(4'd2, 1'b1);
    wait_strobes("loop", w + 1);
    mode_loop = 1'b0;
    wait_idle("loop");
    chk("loop_count", 32'(got.size()), 32'(2 * w));
    for (int i = 0; i < 2 * w && i < got.size(); i++)
      chk($sformatf("loop_w%0d", i), 32'(got[i]), 32'(exp_word(2, i % w)));
    chk("loop_dones", 32'(done_cyc.size()), 32'd2);
    if (done_act.size() == 2) begin
      chk("loop_act1", 32'(done_act[0]), 32'd1);
      chk("loop_act2", 32'(done_act[1]), 32'd0);
    end

    // start held while the transmitter is busy
    clear_log();
    hold_busy = 1'b1;
    len = 4'd3;
    start = 1'b1;
    repeat (5) tick();
    chk("busy_nostrobe", 32'(got.size()), 32'd0);
    chk("busy_inactive", 32'(active), 32'd0);
    hold_busy = 1'b0;
    tick();
    chk("busy_wr", 32'(wr_Sig), 32'd1);
    chk("busy_data", 32'(test_Data), 32'h11);
    start = 1'b0;
    repeat (20) tick();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    wait_idle("busy");
    chk("busy_count", 32'(got.size()), 32'(3 + CK));
    chk("busy_dones", 32'(done_cyc.size()), 32'd1);

    // asynchronous reset while draining word 2
    clear_log();
    run_pass(4'd3, 1'b0);
    wait_strobes("rst", 2);
    repeat (3) tick();
    chk("pre_rst_active", 32'(active), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(wr_Sig), 32'd0);
    chk("mid_rst_data", 32'(test_Data), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("post_rst_nostrobe", 32'(got.size()), 32'd2);
    clear_log();
    run_pass(4'd3, 1'b0);
    wait_idle("restart");
    if (got.size() > 0)
      chk("restart_w0", 32'(got[0]), 32'h11);
    chk("restart_count", 32'(got.size()), 32'(3 + CK));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_pattern_source.md
# uart_pattern_source

Parametrised test-pattern generator that feeds the UART transmitter in the loop-back/bring-up path. It replaces the free-running, fixed 8-byte ROM feeder with a handshaked source: it emits a programmable-length sequence of ROM words to the transmitter on `start`, one word per completed frame. It supports single-pass or continuous loop mode and a configurable inter-word gap. It sits between the board control logic (button/trigger) and `uart_Top`'s `test_Data`/`wr_Sig` inputs.

## Interface
- `DATA_W`, 8: word width; must match transmitter data width.
- `DEPTH`, 8: ROM words, power of two, 2..256; `ADDR_W = $clog2(DEPTH)`.
- `GAP_CYC`, 16: idle clocks inserted after each frame; 0 = back-to-back.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; starts a run when in IDLE.
- `mode_loop`  in  1  1 = restart sequence after each pass; sampled at pass end.
- `len`  in  ADDR_W+1  words per pass; sampled on accepted `start`.
- `tx_busy`  in  1  transmitter busy; high while a frame is shifting.
- `wr_Sig`  out  1  one-cycle write strobe to transmitter.
- `test_Data`  out  DATA_W  word to transmit; valid when `wr_Sig` is high; held until next strobe.
- `active`  out  1  high from accepted `start` until the final pass completes.
- `done`  out  1  one-cycle pulse at the end of every pass.

## Operation
- ROM content is fixed: word i = ((i+1) × 8'h11) mod 2^DATA_W, giving 11,22,…,88 for DEPTH=8.
- Effective length `n`: `len`=0 → DEPTH; `len`>DEPTH → DEPTH; otherwise `len`.
- States: IDLE → SEND → HOLD → DRAIN → GAP → (SEND | IDLE).
- IDLE: if `start`=1 and `tx_busy`=0, latch `n`, idx←0, `active`←1, go to SEND. If `start`=1 and `tx_busy`=1, wait.
- SEND: `wr_Sig`=1 for exactly one cycle with `test_Data`=rom[idx]; then HOLD.
- HOLD: one cycle; `tx_busy` is ignored, which covers the transmitter's one-cycle assertion latency. Then DRAIN.
- DRAIN: wait for `tx_busy`=0, then GAP, or skip GAP when GAP_CYC=0.
- GAP: count GAP_CYC clocks. At the end of the count:
  - idx<n-1: idx++, go to SEND.
  - idx=n-1 (end of pass): pulse `done`.
    - If `mode_loop`=1: idx←0, go to SEND; `active` stays 1.
    - Else: `active`←0, go to IDLE.
- `start` is ignored while `active`=1. Re-assertion does not restart the run.
- Clearing `mode_loop` mid-pass stops the run after the current pass completes.

## Timing
- Reset values: `wr_Sig`=0, `test_Data`=0, `active`=0, `done`=0, state IDLE, idx=0, gap counter=0.
- Latency: `start` accepted at cycle t → `wr_Sig` at t+1.
- Strobe spacing, word k to k+1: 2 + D + GAP_CYC cycles minimum, where D = DRAIN cycles.
- `done` asserts on the cycle the GAP count ends for the last word, coincident with `active` falling in single mode.
- Mid-operation reset: all outputs return to their reset values immediately. No strobe is issued until a new `start` is accepted.
- Index and counters never wrap past `n-1`/GAP_CYC. The idx register is ADDR_W bits wide; `n` is ADDR_W+1 bits wide.

## Configuration
- `UART_SRC_CHECKSUM_EN` defined: after word n-1 of each pass, one extra word is sent with the same SEND/HOLD/DRAIN/GAP sequence.
  - Its value is the XOR of all words sent in that pass.
  - `done` pulses after this checksum word.
- Undefined: no checksum word is sent, and the XOR logic is absent.

## Structure
- Package `uart_src_pkg`:
  - state enum
  - `rom_word(i)` function implementing the ROM formula
  - default-parameter constants
- Sub-module `uart_src_rom`: DEPTH×DATA_W lookup, combinational read on idx, built from `rom_word`.
- FSM, gap counter and checksum accumulator live in the top module.

## Test plan
- Reset, then pulse `start`, `len`=3, `mode_loop`=0, GAP_CYC=4, transmitter model busy 10 cycles → strobes carry 11,22,33; one `done`; `active` falls with `done`.
- `len`=0, DEPTH=8 → 8 words, 11 through 88, then `done`.
- `mode_loop`=1, `len`=2 → 11,22,`done`,11,22,`done`…; drop `mode_loop` mid-second pass → run stops after that pass's `done`.
- `start` held while `tx_busy`=1 → no strobe until `tx_busy`=0, then strobe next cycle; `start` pulsed while `active`=1 → no effect.
- Assert `reset` during DRAIN of word 2 → outputs return to reset values at once; fresh `start` restarts at 11.
- With `UART_SRC_CHECKSUM_EN` and `len`=3 → words 11,22,33,00 (11^22^33), `done` after the fourth word.
